// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional ack timeout is enabled with MEM_ARB_TIMEOUT_EN (see mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } mem_arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Default bus widths, matching the core's AddrBus/DataBus.
    localparam int ADDR_BUS_W = 64;
    localparam int DATA_BUS_W = 64;

    // dcache wins unless both ports want the bus and dcache had the last turn.
    function automatic logic pick_dcache(input logic icache_valid,
                                         input logic dcache_valid,
                                         input logic last_d);
        return dcache_valid && !(icache_valid && last_d);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational priority / round-robin picker between the icache and dcache ports.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic icache_valid,
    input  logic dcache_valid,
    input  logic last_d,
    output logic grant,
    output logic port
);

    assign grant = icache_valid | dcache_valid;
    assign port  = pick_dcache(icache_valid, dcache_valid, last_d) ? PORT_D : PORT_I;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache requests onto one req/ack memory bus.
// Define MEM_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES and raise mem_err_o.
//
//   state  | meaning
//   IDLE   | waiting for a request, arbitrates and launches mem_req_o
//   BUSY_I | icache transaction outstanding on the memory bus
//   BUSY_D | dcache transaction outstanding on the memory bus
//   RESP   | one-cycle completion pulse to the granted port, requests ignored
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_BUS_W,
    parameter int DATA_W         = DATA_BUS_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_req_valid_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    input  logic              icache_data_wen_i,
    input  logic [DATA_W-1:0] icache_data_i,
    output logic              icache_data_valid_o,
    output logic [DATA_W-1:0] icache_data_o,

    input  logic              dcache_req_valid_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic              dcache_data_wen_i,
    input  logic [DATA_W-1:0] dcache_data_i,
    output logic              dcache_data_valid_o,
    output logic [DATA_W-1:0] dcache_data_o,

    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_err_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    mem_arb_state_t    state;
    logic              last_d;
    logic              grant;
    logic              grant_port;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    mem_arb_grant u_grant (
        .icache_valid (icache_req_valid_i),
        .dcache_valid (dcache_req_valid_i),
        .last_d       (last_d),
        .grant        (grant),
        .port         (grant_port)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             timeout_hit;
`else
    assign mem_err_o = 1'b0;
`endif

    // A real ack always beats a timeout landing on the same cycle.
    always_comb begin
        rsp_fire = mem_ack_i;
        rsp_data = mem_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout_hit = !mem_ack_i && (busy_cnt == CNT_LIMIT);
        if (timeout_hit) begin
            rsp_fire = 1'b1;
            rsp_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            last_d              <= 1'b0;
            mem_req_o           <= 1'b0;
            mem_addr_o          <= '0;
            mem_wen_o           <= 1'b0;
            mem_wdata_o         <= '0;
            icache_data_valid_o <= 1'b0;
            icache_data_o       <= '0;
            dcache_data_valid_o <= 1'b0;
            dcache_data_o       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt            <= '0;
            mem_err_o           <= 1'b0;
`endif
        end else begin
            icache_data_valid_o <= 1'b0;
            dcache_data_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        mem_req_o <= 1'b1;
                        last_d    <= (grant_port == PORT_D);
`ifdef MEM_ARB_TIMEOUT_EN
                        busy_cnt  <= '0;
`endif
                        if (grant_port == PORT_D) begin
                            mem_addr_o  <= dcache_addr_i;
                            mem_wen_o   <= dcache_data_wen_i;
                            mem_wdata_o <= dcache_data_i;
                            state       <= BUSY_D;
                        end else begin
                            mem_addr_o  <= icache_addr_i;
                            mem_wen_o   <= icache_data_wen_i;
                            mem_wdata_o <= icache_data_i;
                            state       <= BUSY_I;
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (rsp_fire) begin
                        mem_req_o <= 1'b0;
                        state     <= RESP;
                        if (state == BUSY_I) begin
                            icache_data_o       <= rsp_data;
                            icache_data_valid_o <= 1'b1;
                        end else begin
                            dcache_data_o       <= rsp_data;
                            dcache_data_valid_o <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        if (timeout_hit) begin
                            mem_err_o <= 1'b1;
                        end
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end

                // Requests are deliberately not sampled here so the core can drop them.
                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory model acks after a programmable delay,
// expected bus transactions and port responses are queued when requests are driven.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        icache_req_valid_i;
    logic [63:0] icache_addr_i;
    logic        icache_data_wen_i;
    logic [63:0] icache_data_i;
    logic        icache_data_valid_o;
    logic [63:0] icache_data_o;
    logic        dcache_req_valid_i;
    logic [63:0] dcache_addr_i;
    logic        dcache_data_wen_i;
    logic [63:0] dcache_data_i;
    logic        dcache_data_valid_o;
    logic [63:0] dcache_data_o;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_wen_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_o;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_req_valid_i  (icache_req_valid_i),
        .icache_addr_i       (icache_addr_i),
        .icache_data_wen_i   (icache_data_wen_i),
        .icache_data_i       (icache_data_i),
        .icache_data_valid_o (icache_data_valid_o),
        .icache_data_o       (icache_data_o),
        .dcache_req_valid_i  (dcache_req_valid_i),
        .dcache_addr_i       (dcache_addr_i),
        .dcache_data_wen_i   (dcache_data_wen_i),
        .dcache_data_i       (dcache_data_i),
        .dcache_data_valid_o (dcache_data_valid_o),
        .dcache_data_o       (dcache_data_o),
        .mem_req_o           (mem_req_o),
        .mem_addr_o          (mem_addr_o),
        .mem_wen_o           (mem_wen_o),
        .mem_wdata_o         (mem_wdata_o),
        .mem_ack_i           (mem_ack_i),
        .mem_rdata_i         (mem_rdata_i),
        .mem_err_o           (mem_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
    } mem_exp_t;

    typedef struct {
        bit          port;
        logic [63:0] data;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];

    function automatic logic [63:0] rd_val(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h13;
        return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0]};
    endfunction

    // Memory model: acks mem_delay cycles after mem_req_o rises, checks bus against scoreboard.
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    int          txn_cnt   = 0;
    logic        prev_req  = 1'b0;
    logic [63:0] held_addr;
    logic        held_wen;
    logic [63:0] held_wdata;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
            wait_cnt    = 0;
            prev_req    = 1'b0;
        end else begin
            if (mem_req_o && !prev_req) begin
                txn_cnt++;
                held_addr  = mem_addr_o;
                held_wen   = mem_wen_o;
                held_wdata = mem_wdata_o;
            end else if (mem_req_o && prev_req) begin
                check_val("mem_addr_stable", mem_addr_o, held_addr);
                check_val("mem_wen_stable", 64'(mem_wen_o), 64'(held_wen));
                check_val("mem_wdata_stable", mem_wdata_o, held_wdata);
            end
            prev_req = mem_req_o;

            if (!mem_req_o || mem_ack_i) begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
                wait_cnt    = 0;
            end else if (wait_cnt >= mem_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_val(mem_addr_o);
                wait_cnt    = 0;
                if (exp_mem.size() == 0) begin
                    check_val("mem_unexpected_txn", 64'd1, 64'd0);
                end else begin
                    mem_exp_t e;
                    e = exp_mem.pop_front();
                    check_val("mem_addr", mem_addr_o, e.addr);
                    check_val("mem_wen", 64'(mem_wen_o), 64'(e.wen));
                    check_val("mem_wdata", mem_wdata_o, e.wdata);
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    // Response monitor: every completion pulse is matched against the scoreboard.
    logic prev_iv = 1'b0;
    logic prev_dv = 1'b0;
    int   d_pulses = 0;

    task automatic take_rsp(input bit port, input logic [63:0] data);
        rsp_exp_t e;
        if (exp_rsp.size() == 0) begin
            check_val(port ? "d_rsp_unexpected" : "i_rsp_unexpected", 64'd1, 64'd0);
        end else begin
            e = exp_rsp.pop_front();
            check_val("rsp_port_order", 64'(port), 64'(e.port));
            check_val(port ? "d_rsp_data" : "i_rsp_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_iv = 1'b0;
            prev_dv = 1'b0;
        end else begin
            if (icache_data_valid_o) begin
                check_val("i_pulse_single", 64'(prev_iv), 64'd0);
                take_rsp(1'b0, icache_data_o);
            end
            if (dcache_data_valid_o) begin
                d_pulses++;
                check_val("d_pulse_single", 64'(prev_dv), 64'd0);
                take_rsp(1'b1, dcache_data_o);
            end
            prev_iv = icache_data_valid_o;
            prev_dv = dcache_data_valid_o;
        end
    end

    // Reference arbitration state.
    bit m_last_d = 1'b0;

    task automatic expect_txn(input bit port, input logic [63:0] addr, input logic wen,
                              input logic [63:0] wdata, input logic [63:0] rdata, input bit on_bus);
        mem_exp_t m;
        rsp_exp_t r;
        m.addr = addr; m.wen = wen; m.wdata = wdata;
        r.port = port; r.data = rdata;
        if (on_bus) exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    // Drives one port's request (called just after a falling edge) and waits for its pulse.
    task automatic run_port(input bit port, input logic [63:0] addr, input logic wen,
                            input logic [63:0] wdata, output int lat);
        int start;
        bit seen;
        start = cyc;
        seen  = 1'b0;
        if (port) begin
            dcache_addr_i = addr; dcache_data_wen_i = wen; dcache_data_i = wdata;
            dcache_req_valid_i = 1'b1;
        end else begin
            icache_addr_i = addr; icache_data_wen_i = wen; icache_data_i = wdata;
            icache_req_valid_i = 1'b1;
        end
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (port ? dcache_data_valid_o : icache_data_valid_o) seen = 1'b1;
        end
        lat = cyc - start;
        if (!seen) check_val(port ? "d_done_timeout" : "i_done_timeout", 64'd0, 64'd1);
        if (port) dcache_req_valid_i = 1'b0;
        else      icache_req_valid_i = 1'b0;
    endtask

    task automatic single(input string tag, input bit port, input logic [63:0] addr,
                          input logic wen, input logic [63:0] wdata, input int exp_lat);
        int lat;
        expect_txn(port, addr, wen, wdata, rd_val(addr), 1'b1);
        m_last_d = port;
        run_port(port, addr, wen, wdata, lat);
        check_val(tag, 64'(lat), 64'(exp_lat));
    endtask

    task automatic pair(input logic [63:0] i_addr, input logic [63:0] d_addr);
        int lat_i, lat_d;
        if (m_last_d) begin
            expect_txn(1'b0, i_addr, 1'b0, 64'd0, rd_val(i_addr), 1'b1);
            expect_txn(1'b1, d_addr, 1'b0, 64'd0, rd_val(d_addr), 1'b1);
            m_last_d = 1'b1;
        end else begin
            expect_txn(1'b1, d_addr, 1'b0, 64'd0, rd_val(d_addr), 1'b1);
            expect_txn(1'b0, i_addr, 1'b0, 64'd0, rd_val(i_addr), 1'b1);
            m_last_d = 1'b0;
        end
        fork
            run_port(1'b0, i_addr, 1'b0, 64'd0, lat_i);
            run_port(1'b1, d_addr, 1'b0, 64'd0, lat_d);
        join
        // Winner finishes in 2 cycles, loser waits for the full 3-cycle slot plus its own 2.
        check_val("pair_first_lat", 64'(m_last_d ? lat_i : lat_d), 64'd2);
        check_val("pair_second_lat", 64'(m_last_d ? lat_d : lat_i), 64'd5);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        check_val({tag, "_mem_addr"}, mem_addr_o, 64'd0);
        check_val({tag, "_mem_wen"}, 64'(mem_wen_o), 64'd0);
        check_val({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
        check_val({tag, "_i_valid"}, 64'(icache_data_valid_o), 64'd0);
        check_val({tag, "_i_data"}, icache_data_o, 64'd0);
        check_val({tag, "_d_valid"}, 64'(dcache_data_valid_o), 64'd0);
        check_val({tag, "_d_data"}, dcache_data_o, 64'd0);
        check_val({tag, "_mem_err"}, 64'(mem_err_o), 64'd0);
    endtask

    initial begin
        int lat;
        int txn0;
        int dp0;
        bit seen;

        rst = 1'b1;
        icache_req_valid_i = 1'b0; icache_addr_i = '0; icache_data_wen_i = 1'b0; icache_data_i = '0;
        dcache_req_valid_i = 1'b0; dcache_addr_i = '0; dcache_data_wen_i = 1'b0; dcache_data_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // icache fetch, 0-delay memory: request visible next cycle, pulse 2 cycles after accept.
        mem_delay = 0;
        expect_txn(1'b0, 64'h8000_0000, 1'b0, 64'd0, 64'h13, 1'b1);
        m_last_d = 1'b0;
        fork
            run_port(1'b0, 64'h8000_0000, 1'b0, 64'd0, lat);
            begin
                @(negedge clk);
                check_val("t1_mem_req", 64'(mem_req_o), 64'd1);
                check_val("t1_mem_addr", mem_addr_o, 64'h8000_0000);
            end
        join
        check_val("t1_latency", 64'(lat), 64'd2);
        repeat (3) @(negedge clk);
        check_val("t1_data_hold", icache_data_o, 64'h13);

        // Contention with last_d=0, then a dcache-only op, then contention with last_d=1.
        pair(64'h8000_0100, 64'h8000_0200);
        @(negedge clk);
        single("t3_d_latency", 1'b1, 64'h8000_0300, 1'b0, 64'd0, 2);
        @(negedge clk);
        pair(64'h8000_0140, 64'h8000_0240);
        @(negedge clk);

        // dcache write held across a 5-cycle ack delay.
        mem_delay = 5;
        single("t5_w_latency", 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF_0000_0001, 7);
        check_val("t5_i_data_hold", icache_data_o, rd_val(64'h8000_0140));
        check_val("t5_d_data", dcache_data_o, rd_val(64'h8000_1000));
        mem_delay = 0;
        @(negedge clk);

        // Core keeps its request high across the RESP edge: still only one transaction.
        txn0 = txn_cnt;
        expect_txn(1'b0, 64'h8000_0400, 1'b0, 64'd0, rd_val(64'h8000_0400), 1'b1);
        m_last_d = 1'b0;
        icache_addr_i = 64'h8000_0400; icache_data_wen_i = 1'b0; icache_data_i = '0;
        icache_req_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (icache_data_valid_o) seen = 1'b1;
        end
        check_val("t6_pulse_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        icache_req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t6_one_txn", 64'(txn_cnt - txn0), 64'd1);
        check_val("t6_req_idle", 64'(mem_req_o), 64'd0);

        // Reset while a dcache transaction is outstanding.
        mem_delay = 50;
        dp0 = d_pulses;
        dcache_addr_i = 64'h8000_0500; dcache_data_wen_i = 1'b1; dcache_data_i = 64'h1234;
        dcache_req_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_o) seen = 1'b1;
        end
        check_val("t7_busy_d", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t7_async_rst");
        dcache_req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b0;
        mem_delay = 0;
        repeat (3) @(negedge clk);
        check_val("t7_no_d_pulse", 64'(d_pulses - dp0), 64'd0);
        single("t7_after_rst_lat", 1'b0, 64'h8000_0600, 1'b0, 64'd0, 2);
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: zero data after 8 busy cycles, sticky error.
        mem_delay = 100000;
        expect_txn(1'b0, 64'h8000_0700, 1'b0, 64'd0, 64'd0, 1'b0);
        m_last_d = 1'b0;
        run_port(1'b0, 64'h8000_0700, 1'b0, 64'd0, lat);
        check_val("t8_timeout_lat", 64'(lat), 64'd9);
        check_val("t8_err_set", 64'(mem_err_o), 64'd1);
        mem_delay = 0;
        repeat (4) @(negedge clk);
        check_val("t8_err_sticky", 64'(mem_err_o), 64'd1);
`else
        check_val("err_tied_low", 64'(mem_err_o), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check_val("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check_val("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
